// File: rtl/sda_kernel_ctrl_result.sv
// Result RAM: kernel writes return values over a SELF channel; the host reads them back over the register bus.
// Latency: kernel write token 3 cycles after acceptance; host read ack 3 cycles after regReq edge, host write ack 1 cycle.
// Backpressure: stall chain ack -> S2 -> input buffer; resultReqStop is the input-buffer stall.
//
// Ports:
//   clk, arstn                   clock, asynchronous active-low reset
//   regReq/regAck/regWriteEn     host register handshake (level request, one-cycle ack)
//   regAddr/regWData/regWStrb    host address and write payload (payload unused: RAM is read-only to host)
//   regRData                     host read data, zero whenever regAck is low
//   resultReqValid/resultReqStop kernel write request handshake
//   resultAddr/resultData/Strb   kernel write payload (LSB-justified data and strobes)
//   resultAckValid/resultAckStop kernel write-complete token handshake
module sda_kernel_ctrl_result #(
    parameter int unsigned RegAddrWidth = 12,
    parameter logic [RegAddrWidth-1:0] ResultAddrBase = 12'd64,
    parameter logic [RegAddrWidth-1:0] ResultAddrTop  = 12'd4095
) (
    input  logic                    clk,
    input  logic                    arstn,
    input  logic                    regReq,
    output logic                    regAck,
    input  logic                    regWriteEn,
    input  logic [RegAddrWidth-1:0] regAddr,
    input  logic [31:0]             regWData,
    input  logic [3:0]              regWStrb,
    output logic [31:0]             regRData,
    input  logic                    resultReqValid,
    input  logic [31:0]             resultAddr,
    input  logic [31:0]             resultData,
    input  logic [3:0]              resultStrb,
    output logic                    resultReqStop,
    output logic                    resultAckValid,
    input  logic                    resultAckStop
);

    localparam int unsigned WordW = RegAddrWidth - 2;
    localparam int unsigned Depth = (int'(ResultAddrTop) - int'(ResultAddrBase) + 1) / 4;
    localparam int unsigned IdxW  = $clog2(Depth);
    localparam logic [WordW-1:0] BaseWord = ResultAddrBase[RegAddrWidth-1:2];

    // Raw kernel request as held in the input buffer.
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] dat;
        logic [3:0]  strb;
    } kreq_t;

    // Decoded and lane-aligned write, presented to the RAM write port.
    typedef struct packed {
        logic [IdxW-1:0] idx;
        logic [31:0]     dat;
        logic [3:0]      strb;
        logic            hit;
    } wr_t;

    function automatic logic in_window(input logic [RegAddrWidth-1:0] a);
        // One extra MSB keeps the upper-bound compare meaningful when the top is all-ones.
        return ({1'b0, a} >= {1'b0, ResultAddrBase}) &&
               ({1'b0, a} <= {1'b0, ResultAddrTop});
    endfunction

    function automatic logic [IdxW-1:0] word_idx(input logic [WordW-1:0] w);
        logic [WordW-1:0] rel;
        rel = w - BaseWord;
        return rel[IdxW-1:0];
    endfunction

    function automatic logic [31:0] rot_dat(input logic [31:0] d, input logic [1:0] sh);
        logic [31:0] r;
        case (sh)
            2'd0:    r = d;
            2'd1:    r = {d[23:0], d[31:24]};
            2'd2:    r = {d[15:0], d[31:16]};
            default: r = {d[7:0],  d[31:8]};
        endcase
        return r;
    endfunction

    function automatic logic [3:0] rot_strb(input logic [3:0] s, input logic [1:0] sh);
        logic [3:0] r;
        case (sh)
            2'd0:    r = s;
            2'd1:    r = {s[2:0], s[3]};
            2'd2:    r = {s[1:0], s[3:2]};
            default: r = {s[0],   s[3:1]};
        endcase
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Kernel write pipeline: input buffer -> S1 decode -> S2 RAM write -> ack token
    // ------------------------------------------------------------------
    logic  ib_vld_q, ib_vld_d;
    kreq_t ib_q, ib_d;
    logic  s2_vld_q, s2_vld_d;
    wr_t   s2_q, s2_d;
    logic  ack_vld_q, ack_vld_d;

    logic ack_stall, s2_stall, ib_stall;
    logic ram_we;

    // A stage stalls only when it holds data and the stage after it stalls.
    assign ack_stall = ack_vld_q & resultAckStop;
    assign s2_stall  = s2_vld_q  & ack_stall;
    assign ib_stall  = ib_vld_q  & s2_stall;

    assign resultReqStop  = ib_stall;
    assign resultAckValid = ack_vld_q;

    // Out-of-window writes still travel the pipe so they earn a token; only the RAM write is masked.
    assign ram_we = s2_vld_q & ~s2_stall & s2_q.hit;

    always_comb begin
        ib_vld_d  = ib_vld_q;
        ib_d      = ib_q;
        s2_vld_d  = s2_vld_q;
        s2_d      = s2_q;
        ack_vld_d = ack_vld_q;

        if (!ib_stall) begin
            ib_vld_d = resultReqValid;
            if (resultReqValid) begin
                ib_d.addr = resultAddr;
                ib_d.dat  = resultData;
                ib_d.strb = resultStrb;
            end
        end

        if (!s2_stall) begin
            s2_vld_d = ib_vld_q;
            if (ib_vld_q) begin
                s2_d.hit  = (ib_q.addr[31:RegAddrWidth] == '0) &&
                            in_window(ib_q.addr[RegAddrWidth-1:0]);
                s2_d.idx  = word_idx(ib_q.addr[RegAddrWidth-1:2]);
                s2_d.dat  = rot_dat(ib_q.dat, ib_q.addr[1:0]);
                s2_d.strb = rot_strb(ib_q.strb, ib_q.addr[1:0]);
            end
        end

        if (!ack_stall) begin
            ack_vld_d = s2_vld_q;
        end
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            ib_vld_q  <= 1'b0;
            ib_q      <= '0;
            s2_vld_q  <= 1'b0;
            s2_q      <= '0;
            ack_vld_q <= 1'b0;
        end else begin
            ib_vld_q  <= ib_vld_d;
            ib_q      <= ib_d;
            s2_vld_q  <= s2_vld_d;
            s2_q      <= s2_d;
            ack_vld_q <= ack_vld_d;
        end
    end

    // ------------------------------------------------------------------
    // Host register access
    // ------------------------------------------------------------------
    logic            req_q;
    logic            host_edge, host_hit;
    logic            rd1_vld_q, rd1_vld_d;
    logic [IdxW-1:0] rd_idx_q, rd_idx_d;
    logic            rd2_vld_q;
    logic            rd3_vld_q;
    logic [31:0]     rd3_dat_q, rd3_dat_d;
    logic            wr_ack_q, wr_ack_d;
    logic [31:0]     ram_dout_q;

    assign host_edge = regReq & ~req_q;
    assign host_hit  = in_window(regAddr);

    always_comb begin
        rd1_vld_d = host_edge & host_hit & ~regWriteEn;
        rd_idx_d  = rd_idx_q;
        if (rd1_vld_d) begin
            rd_idx_d = word_idx(regAddr[RegAddrWidth-1:2]);
        end
        // Host writes are acknowledged but never touch the RAM.
        wr_ack_d  = host_edge & host_hit & regWriteEn;
        // Data register is zero outside the ack cycle so the ORed read bus stays clean.
        rd3_dat_d = rd2_vld_q ? ram_dout_q : 32'd0;
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            req_q     <= 1'b0;
            rd1_vld_q <= 1'b0;
            rd_idx_q  <= '0;
            rd2_vld_q <= 1'b0;
            rd3_vld_q <= 1'b0;
            rd3_dat_q <= 32'd0;
            wr_ack_q  <= 1'b0;
        end else begin
            req_q     <= regReq;
            rd1_vld_q <= rd1_vld_d;
            rd_idx_q  <= rd_idx_d;
            rd2_vld_q <= rd1_vld_q;
            rd3_vld_q <= rd2_vld_q;
            rd3_dat_q <= rd3_dat_d;
            wr_ack_q  <= wr_ack_d;
        end
    end

    assign regAck   = rd3_vld_q | wr_ack_q;
    assign regRData = rd3_dat_q;

    // ------------------------------------------------------------------
    // Simple dual-port RAM, byte write enables, no array reset.
    // Read and write share the edge, so a same-word collision returns the old word.
    // ------------------------------------------------------------------
    logic [31:0] mem [Depth];

    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (s2_q.strb[b]) begin
                    mem[s2_q.idx][8*b +: 8] <= s2_q.dat[8*b +: 8];
                end
            end
        end
        if (rd1_vld_q) begin
            ram_dout_q <= mem[rd_idx_q];
        end
    end

    // Host write payload and byte offset are intentionally ignored.
    logic unused_host;
    assign unused_host = ^{regWData, regWStrb, regAddr[1:0]};

endmodule

// File: tb/tb_sda_kernel_ctrl_result.sv
module tb_sda_kernel_ctrl_result;

    logic        clk = 1'b0;
    logic        arstn;
    logic        regReq;
    logic        regAck;
    logic        regWriteEn;
    logic [11:0] regAddr;
    logic [31:0] regWData;
    logic [3:0]  regWStrb;
    logic [31:0] regRData;
    logic        resultReqValid;
    logic [31:0] resultAddr;
    logic [31:0] resultData;
    logic [3:0]  resultStrb;
    logic        resultReqStop;
    logic        resultAckValid;
    logic        resultAckStop;

    int checks  = 0;
    int errors  = 0;
    int tok_cnt = 0;

    always #5 clk = ~clk;

    sda_kernel_ctrl_result dut (
        .clk            (clk),
        .arstn          (arstn),
        .regReq         (regReq),
        .regAck         (regAck),
        .regWriteEn     (regWriteEn),
        .regAddr        (regAddr),
        .regWData       (regWData),
        .regWStrb       (regWStrb),
        .regRData       (regRData),
        .resultReqValid (resultReqValid),
        .resultAddr     (resultAddr),
        .resultData     (resultData),
        .resultStrb     (resultStrb),
        .resultReqStop  (resultReqStop),
        .resultAckValid (resultAckValid),
        .resultAckStop  (resultAckStop)
    );

    // Count every token actually transferred on the ack channel.
    always @(posedge clk) begin
        if (arstn && resultAckValid && !resultAckStop) tok_cnt <= tok_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Starts at a negedge; returns at the negedge after the accepting posedge.
    task automatic kwr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int n;
        resultReqValid = 1'b1;
        resultAddr     = a;
        resultData     = d;
        resultStrb     = s;
        n = 0;
        #1;
        while (resultReqStop && n < 60) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("kwr_accept", 32'(n < 60), 32'd1);
        @(negedge clk);
        resultReqValid = 1'b0;
    endtask

    task automatic wait_tok(input string tag, input int target);
        int n;
        n = 0;
        while (tok_cnt < target && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(tok_cnt), 32'(target));
    endtask

    // exp_cyc = cycle after the request edge where the single ack is expected, 0 = no ack.
    task automatic hacc(input string tag, input logic [11:0] a, input logic we,
                        input int exp_cyc, input logic [31:0] exp_dat);
        int acks, cyc;
        logic [31:0] dat;
        logic zero_ok;
        regReq     = 1'b1;
        regWriteEn = we;
        regAddr    = a;
        regWData   = 32'hFFFF_FFFF;
        regWStrb   = 4'hF;
        acks = 0; cyc = 0; dat = '0; zero_ok = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (regAck) begin
                acks++;
                cyc = k;
                dat = regRData;
            end else if (regRData !== 32'd0) begin
                zero_ok = 1'b0;
            end
        end
        regReq = 1'b0;
        @(negedge clk);
        chk({tag, "_acks"}, 32'(acks), (exp_cyc != 0) ? 32'd1 : 32'd0);
        chk({tag, "_cyc"}, 32'(cyc), 32'(exp_cyc));
        if (exp_cyc != 0 && !we) chk({tag, "_dat"}, dat, exp_dat);
        chk({tag, "_idle0"}, {31'd0, zero_ok}, 32'd1);
    endtask

    initial begin
        int base;
        arstn = 1'b0; regReq = 1'b0; regWriteEn = 1'b0; regAddr = '0;
        regWData = '0; regWStrb = '0; resultReqValid = 1'b0; resultAddr = '0;
        resultData = '0; resultStrb = '0; resultAckStop = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_regAck", {31'd0, regAck}, 32'd0);
        chk("rst_regRData", regRData, 32'd0);
        chk("rst_reqStop", {31'd0, resultReqStop}, 32'd0);
        chk("rst_ackValid", {31'd0, resultAckValid}, 32'd0);
        arstn = 1'b1;
        @(negedge clk);

        // 1: full word, token latency, host read latency
        kwr(32'h40, 32'hDEAD_BEEF, 4'hF);
        chk("lat_c1", {31'd0, resultAckValid}, 32'd0);
        @(negedge clk);
        chk("lat_c2", {31'd0, resultAckValid}, 32'd0);
        @(negedge clk);
        chk("lat_c3", {31'd0, resultAckValid}, 32'd1);
        wait_tok("t1_tok", 1);
        hacc("t1_rd", 12'h040, 1'b0, 3, 32'hDEAD_BEEF);

        // 2: byte lane alignment and strobe wrap
        kwr(32'h42, 32'h0000_00AB, 4'b0001);
        wait_tok("t2a_tok", 2);
        hacc("t2a_rd", 12'h040, 1'b0, 3, 32'hDEAB_BEEF);
        kwr(32'h43, 32'h0000_1234, 4'b0011);
        wait_tok("t2b_tok", 3);
        hacc("t2b_rd", 12'h040, 1'b0, 3, 32'h34AB_BE12);

        // 3: out-of-window kernel writes get tokens but leave the RAM alone
        kwr(32'h10, 32'h0000_0055, 4'hF);
        wait_tok("t3a_tok", 4);
        kwr(32'h0000_1040, 32'h0000_0055, 4'hF);
        wait_tok("t3b_tok", 5);
        hacc("t3_rd40", 12'h040, 1'b0, 3, 32'h34AB_BE12);
        hacc("t3_rd10", 12'h010, 1'b0, 0, 32'd0);
        hacc("t3_rd3c", 12'h03C, 1'b0, 0, 32'd0);

        // top word of the window
        kwr(32'hFFC, 32'hCAFE_F00D, 4'hF);
        wait_tok("top_tok", 6);
        hacc("top_rd", 12'hFFC, 1'b0, 3, 32'hCAFE_F00D);

        // 4: ack backpressure with 5 queued writes
        base = tok_cnt;
        resultAckStop = 1'b1;
        fork
            begin
                for (int i = 0; i < 5; i++)
                    kwr(32'h44 + 32'(4 * i), 32'hC0DE_0000 ^ (32'h0101_0101 * 32'(i + 1)), 4'hF);
            end
            begin
                repeat (12) @(negedge clk);
                chk("t4_reqStop", {31'd0, resultReqStop}, 32'd1);
                chk("t4_held", 32'(tok_cnt), 32'(base));
                resultAckStop = 1'b0;
            end
        join
        wait_tok("t4_tok", base + 5);
        repeat (4) @(negedge clk);
        chk("t4_noextra", 32'(tok_cnt), 32'(base + 5));
        hacc("t4_rd0", 12'h044, 1'b0, 3, 32'hC1DF_0101);
        hacc("t4_rd1", 12'h048, 1'b0, 3, 32'hC2DC_0202);
        hacc("t4_rd2", 12'h04C, 1'b0, 3, 32'hC3DD_0303);
        hacc("t4_rd3", 12'h050, 1'b0, 3, 32'hC4DA_0404);
        hacc("t4_rd4", 12'h054, 1'b0, 3, 32'hC5DB_0505);

        // 5: host write is acked at N+1 and does not modify the RAM
        hacc("t5_wr", 12'h040, 1'b1, 1, 32'd0);
        hacc("t5_rd", 12'h040, 1'b0, 3, 32'h34AB_BE12);

        // 6: reset with writes in flight
        base = tok_cnt;
        resultAckStop = 1'b1;
        kwr(32'h58, 32'h1122_3344, 4'hF);
        kwr(32'h5C, 32'h5566_7788, 4'hF);
        @(negedge clk);
        chk("t6_pre_ackValid", {31'd0, resultAckValid}, 32'd1);
        arstn = 1'b0;
        #1;
        chk("t6_ackValid", {31'd0, resultAckValid}, 32'd0);
        chk("t6_reqStop", {31'd0, resultReqStop}, 32'd0);
        chk("t6_regAck", {31'd0, regAck}, 32'd0);
        chk("t6_regRData", regRData, 32'd0);
        @(negedge clk);
        arstn = 1'b1;
        resultAckStop = 1'b0;
        repeat (6) @(negedge clk);
        chk("t6_notok", 32'(tok_cnt), 32'(base));
        kwr(32'h60, 32'h0BAD_F00D, 4'hF);
        wait_tok("t6_newtok", base + 1);
        hacc("t6_rd", 12'h060, 1'b0, 3, 32'h0BAD_F00D);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
